// File: rtl/chan_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : chan_pkt_fifo
// Purpose  : Per-channel TX packet ring buffer with show-ahead reader port and
//            whole-packet drop on overflow. Optional statistics counters are
//            enabled with `define CHAN_PKT_FIFO_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chan_pkt_fifo #(
    parameter int PKT_WORDS = 128,
    parameter int NUM_PKTS  = 4,
    parameter int ADDR_W    = 9
) (
    input  logic                      tx_clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wrreq,
    input  logic [31:0]               wrdata,
    output logic                      have_space,
    output logic                      overrun,
    input  logic                      rdreq,
    input  logic                      skip,
    output logic [31:0]               fifodata,
    output logic                      pkt_waiting,
    output logic [$clog2(NUM_PKTS):0] pkt_count
`ifdef CHAN_PKT_FIFO_STATS_EN
    ,
    output logic [15:0]               pkts_rcvd,
    output logic [15:0]               pkts_dropped
`endif
);

    localparam int c_SLOT_W = $clog2(NUM_PKTS);
    localparam int c_WORD_W = $clog2(PKT_WORDS);
    localparam int c_CNT_W  = c_SLOT_W + 1;

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(NUM_PKTS);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(PKT_WORDS - 1);
    localparam logic [c_WORD_W-1:0] c_WORD_ONE  = c_WORD_W'(1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);

    localparam logic [0:0] c_ST_ACCEPT = 1'b0;
    localparam logic [0:0] c_ST_DROP   = 1'b1;

    logic [0:0]          r_state;
    logic [c_WORD_W-1:0] r_wr_word;
    logic [c_WORD_W-1:0] r_rd_word;
    logic [c_SLOT_W-1:0] r_rd_pkt;
    logic [c_CNT_W-1:0]  r_pkt_count;
    logic                r_overrun;
    logic [31:0]         r_fifodata;

    logic [c_WORD_W-1:0] w_rd_word_nxt;
    logic [c_SLOT_W-1:0] w_rd_pkt_nxt;
    logic [c_SLOT_W-1:0] w_wr_slot;
    logic [c_CNT_W-1:0]  w_pkt_count_nxt;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_has_pkt;
    logic                w_accepting;
    logic                w_drop_start;
    logic                w_store;
    logic                w_commit;
    logic                w_skip_take;
    logic                w_advance;

    logic [31:0] r_mem [0:(2**ADDR_W)-1];

    assign w_has_pkt    = (r_pkt_count != '0);
    assign w_accepting  = wrreq && (r_state == c_ST_ACCEPT);
    assign w_drop_start = w_accepting && (r_wr_word == '0) && (r_pkt_count == c_FULL);
    assign w_store      = w_accepting && !w_drop_start;
    assign w_commit     = w_store && (r_wr_word == c_LAST_WORD);
    assign w_skip_take  = skip && w_has_pkt;
    assign w_advance    = rdreq && !skip && w_has_pkt && (r_rd_word != c_LAST_WORD);

    // The write slot sits just past the committed packets; a partial packet
    // keeps the same slot even when the reader releases packets meanwhile.
    assign w_wr_slot = r_rd_pkt + r_pkt_count[c_SLOT_W-1:0];
    assign w_wr_addr = {w_wr_slot, r_wr_word};
    assign w_rd_addr = {w_rd_pkt_nxt, w_rd_word_nxt};

    always_comb begin
        w_rd_pkt_nxt  = r_rd_pkt;
        w_rd_word_nxt = r_rd_word;
        if (w_skip_take) begin
            w_rd_pkt_nxt  = r_rd_pkt + c_SLOT_ONE;
            w_rd_word_nxt = '0;
        end else if (w_advance) begin
            w_rd_word_nxt = r_rd_word + c_WORD_ONE;
        end
    end

    always_comb begin
        w_pkt_count_nxt = r_pkt_count;
        if (w_commit && !w_skip_take) begin
            w_pkt_count_nxt = r_pkt_count + c_CNT_ONE;
        end else if (!w_commit && w_skip_take) begin
            w_pkt_count_nxt = r_pkt_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge tx_clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_ACCEPT;
            r_wr_word   <= '0;
            r_rd_word   <= '0;
            r_rd_pkt    <= '0;
            r_pkt_count <= '0;
            r_overrun   <= 1'b0;
            r_fifodata  <= '0;
        end else if (clear) begin
            r_state     <= c_ST_ACCEPT;
            r_wr_word   <= '0;
            r_rd_word   <= '0;
            r_rd_pkt    <= '0;
            r_pkt_count <= '0;
            r_overrun   <= 1'b0;
            r_fifodata  <= '0;
        end else begin
            // Word counter runs in both states; in DROP it counts discarded
            // words so the FSM resynchronises on the next packet boundary.
            if (wrreq) begin
                r_wr_word <= r_wr_word + c_WORD_ONE;
            end
            if (w_drop_start) begin
                r_state   <= c_ST_DROP;
                r_overrun <= 1'b1;
            end else if (wrreq && (r_state == c_ST_DROP) && (r_wr_word == c_LAST_WORD)) begin
                r_state <= c_ST_ACCEPT;
            end
            r_rd_pkt    <= w_rd_pkt_nxt;
            r_rd_word   <= w_rd_word_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_fifodata  <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge tx_clock) begin
        if (w_store && !clear && reset) begin
            r_mem[w_wr_addr] <= wrdata;
        end
    end

    assign have_space  = (r_pkt_count < c_FULL);
    assign overrun     = r_overrun;
    assign fifodata    = r_fifodata;
    assign pkt_count   = r_pkt_count;
    assign pkt_waiting = ((r_pkt_count - {{(c_CNT_W-1){1'b0}}, w_skip_take}) != '0);

`ifdef CHAN_PKT_FIFO_STATS_EN
    logic [15:0] r_pkts_rcvd;
    logic [15:0] r_pkts_dropped;

    always_ff @(posedge tx_clock or negedge reset) begin
        if (!reset) begin
            r_pkts_rcvd    <= '0;
            r_pkts_dropped <= '0;
        end else if (clear) begin
            r_pkts_rcvd    <= '0;
            r_pkts_dropped <= '0;
        end else begin
            if (w_commit) begin
                r_pkts_rcvd <= r_pkts_rcvd + 16'd1;
            end
            if (w_drop_start) begin
                r_pkts_dropped <= r_pkts_dropped + 16'd1;
            end
        end
    end

    assign pkts_rcvd    = r_pkts_rcvd;
    assign pkts_dropped = r_pkts_dropped;
`endif

endmodule
`default_nettype wire
